// File: rtl/sram_bus_arbiter_if.sv
// sram_bus_arbiter_if: fetch, load/store and external SRAM bus signals shared by the arbiter
interface sram_bus_arbiter_if;
  logic        inst_req;
  logic [31:0] inst_addr;
  logic        inst_addr_ok;
  logic        inst_data_ok;
  logic [31:0] inst_rdata;
  logic        data_req;
  logic        data_wr;
  logic [1:0]  data_size;
  logic [3:0]  data_wstrb;
  logic [31:0] data_addr;
  logic [31:0] data_wdata;
  logic        data_addr_ok;
  logic        data_data_ok;
  logic [31:0] data_rdata;
  logic        bus_req;
  logic        bus_wr;
  logic [1:0]  bus_size;
  logic [3:0]  bus_wstrb;
  logic [31:0] bus_addr;
  logic [31:0] bus_wdata;
  logic        bus_addr_ok;
  logic        bus_data_ok;
  logic [31:0] bus_rdata;
  modport slave (
    input  inst_req, inst_addr,
    input  data_req, data_wr, data_size, data_wstrb, data_addr, data_wdata,
    input  bus_addr_ok, bus_data_ok, bus_rdata,
    output inst_addr_ok, inst_data_ok, inst_rdata,
    output data_addr_ok, data_data_ok, data_rdata,
    output bus_req, bus_wr, bus_size, bus_wstrb, bus_addr, bus_wdata
  );
  modport master (
    output inst_req, inst_addr,
    output data_req, data_wr, data_size, data_wstrb, data_addr, data_wdata,
    output bus_addr_ok, bus_data_ok, bus_rdata,
    input  inst_addr_ok, inst_data_ok, inst_rdata,
    input  data_addr_ok, data_data_ok, data_rdata,
    input  bus_req, bus_wr, bus_size, bus_wstrb, bus_addr, bus_wdata
  );
endinterface

// File: rtl/sram_bus_arbiter.sv
// sram_bus_arbiter: shares one SRAM-like bus between fetch and load/store, one transaction outstanding
module sram_bus_arbiter #(
  parameter int unsigned STARVE_MAX = 2
) (
  input  logic              clk,
  input  logic              reset,
  sram_bus_arbiter_if.slave bus
);
  typedef enum logic [1:0] {IDLE, REQ, WAIT} state_t;
  localparam logic [2:0] SMAX = 3'(STARVE_MAX);
  state_t     state_q, state_d;
  logic       owner_q, owner_d;
  logic [2:0] cnt_q, cnt_d;
  logic       in_req, in_wait, arb_now, data_wins;
  // state, owner (1 = load/store) and data-streak counter
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      owner_q <= 1'b0;
      cnt_q   <= 3'd0;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      cnt_q   <= cnt_d;
    end
  end
  // arbitration on a free bus (idle, or the response arriving), grant lock in REQ, output muxing
  always_comb begin
    in_req    = state_q == REQ;
    in_wait   = state_q == WAIT;
    arb_now   = state_q == IDLE || (in_wait && bus.bus_data_ok);
    data_wins = bus.data_req && !(bus.inst_req && cnt_q == SMAX);
    state_d   = state_q;
    owner_d   = owner_q;
    cnt_d     = cnt_q;
    if (arb_now && (bus.inst_req || bus.data_req)) begin
      state_d = REQ;
      owner_d = data_wins;
      cnt_d   = !data_wins ? 3'd0 : (bus.inst_req && cnt_q != SMAX) ? cnt_q + 3'd1 : cnt_q;
    end else if (arb_now) begin
      state_d = IDLE;
    end else if (in_req && bus.bus_addr_ok) begin
      state_d = WAIT;
    end
    bus.bus_req      = in_req;
    bus.bus_wr       = in_req && owner_q && bus.data_wr;
    bus.bus_size     = !in_req ? 2'd0 : owner_q ? bus.data_size : 2'd2;
    bus.bus_wstrb    = (in_req && owner_q) ? bus.data_wstrb : 4'd0;
    bus.bus_addr     = !in_req ? 32'd0 : owner_q ? bus.data_addr : bus.inst_addr;
    bus.bus_wdata    = (in_req && owner_q) ? bus.data_wdata : 32'd0;
    bus.inst_addr_ok = in_req && !owner_q && bus.bus_addr_ok;
    bus.data_addr_ok = in_req && owner_q && bus.bus_addr_ok;
    bus.inst_data_ok = in_wait && !owner_q && bus.bus_data_ok;
    bus.data_data_ok = in_wait && owner_q && bus.bus_data_ok;
    bus.inst_rdata   = bus.bus_rdata;
    bus.data_rdata   = bus.bus_rdata;
  end
endmodule

// File: tb/tb_sram_bus_arbiter.sv
// tb_sram_bus_arbiter: directed scenarios plus randomized traffic against a transaction-level model
module tb_sram_bus_arbiter;
  localparam int SM = 2;
  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;
  sram_bus_arbiter_if ifc();
  sram_bus_arbiter #(.STARVE_MAX(SM)) dut (.clk(clk), .reset(reset), .bus(ifc));
  int total = 0;
  int passed = 0;
  int ph = 0;
  int who = 0;
  int streak = 0;
  logic s_ia, s_da, s_ao, s_dk, s_rs;
  int obs_grants[$];
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: got %h expected %h", tag, obs, exp);
  endtask
  task automatic check_outputs();
    logic r, di, dd;
    r  = ph == 1;
    di = ph == 1 && who == 1;
    chk("bus_req", ifc.bus_req, r);
    if (ph != 2) begin
      chk("bus_addr", ifc.bus_addr, !r ? 32'd0 : di ? ifc.data_addr : ifc.inst_addr);
      chk("bus_wr", ifc.bus_wr, di ? ifc.data_wr : 1'b0);
      chk("bus_size", ifc.bus_size, !r ? 2'd0 : di ? ifc.data_size : 2'd2);
      chk("bus_wstrb", ifc.bus_wstrb, di ? ifc.data_wstrb : 4'd0);
      chk("bus_wdata", ifc.bus_wdata, di ? ifc.data_wdata : 32'd0);
    end
    chk("inst_addr_ok", ifc.inst_addr_ok, r && who == 0 && ifc.bus_addr_ok);
    chk("data_addr_ok", ifc.data_addr_ok, r && who == 1 && ifc.bus_addr_ok);
    dd = ph == 2 && ifc.bus_data_ok;
    chk("inst_data_ok", ifc.inst_data_ok, dd && who == 0);
    chk("data_data_ok", ifc.data_data_ok, dd && who == 1);
    chk("inst_rdata", ifc.inst_rdata, ifc.bus_rdata);
    chk("data_rdata", ifc.data_rdata, ifc.bus_rdata);
  endtask
  task automatic settle();
    #3;
    check_outputs();
    s_ia = ifc.inst_req;
    s_da = ifc.data_req;
    s_ao = ifc.bus_addr_ok;
    s_dk = ifc.bus_data_ok;
    s_rs = reset;
    if (ifc.inst_addr_ok) obs_grants.push_back(0);
    if (ifc.data_addr_ok) obs_grants.push_back(1);
  endtask
  task automatic advance();
    logic free, win;
    @(posedge clk);
    if (s_rs) begin
      ph = 0;
      who = 0;
      streak = 0;
    end else begin
      free = ph == 0 || (ph == 2 && s_dk);
      if (ph == 1 && s_ao) ph = 2;
      if (free && (s_ia || s_da)) begin
        win = s_da && !(s_ia && streak == SM);
        if (!win) streak = 0;
        else if (s_ia && streak < SM) streak = streak + 1;
        who = int'(win);
        ph = 1;
      end else if (free) begin
        ph = 0;
      end
    end
    #1;
  endtask
  task automatic step();
    settle();
    advance();
  endtask
  task automatic clear_bus();
    ifc.bus_addr_ok = 1'b0;
    ifc.bus_data_ok = 1'b0;
  endtask
  initial begin
    int exp_order[6];
    logic i_acc, d_acc;
    exp_order = '{1, 1, 0, 1, 1, 0};
    reset = 1'b1;
    ifc.inst_req = 1'b0;
    ifc.inst_addr = 32'd0;
    ifc.data_req = 1'b0;
    ifc.data_wr = 1'b0;
    ifc.data_size = 2'd0;
    ifc.data_wstrb = 4'd0;
    ifc.data_addr = 32'd0;
    ifc.data_wdata = 32'd0;
    ifc.bus_addr_ok = 1'b0;
    ifc.bus_data_ok = 1'b0;
    ifc.bus_rdata = 32'd0;
    repeat (2) @(posedge clk);
    #1;
    settle();
    chk("rst_bus_req", ifc.bus_req, 1'b0);
    chk("rst_bus_addr", ifc.bus_addr, 32'd0);
    advance();
    reset = 1'b0;
    ifc.inst_req = 1'b1;
    ifc.inst_addr = 32'h1C00_0000;
    step();
    ifc.bus_addr_ok = 1'b1;
    settle();
    chk("fetch_bus_req", ifc.bus_req, 1'b1);
    chk("fetch_bus_addr", ifc.bus_addr, 32'h1C00_0000);
    chk("fetch_addr_ok", ifc.inst_addr_ok, 1'b1);
    advance();
    ifc.inst_req = 1'b0;
    ifc.bus_addr_ok = 1'b0;
    settle();
    chk("fetch_wait_req", ifc.bus_req, 1'b0);
    advance();
    ifc.bus_data_ok = 1'b1;
    ifc.bus_rdata = 32'h0280_0C0C;
    settle();
    chk("fetch_data_ok", ifc.inst_data_ok, 1'b1);
    chk("fetch_rdata", ifc.inst_rdata, 32'h0280_0C0C);
    chk("fetch_dside_ok", ifc.data_data_ok, 1'b0);
    advance();
    clear_bus();
    step();
    ifc.data_req = 1'b1;
    ifc.data_wr = 1'b1;
    ifc.data_size = 2'd0;
    ifc.data_wstrb = 4'b0100;
    ifc.data_addr = 32'h1000_0002;
    ifc.data_wdata = 32'h00AB_0000;
    step();
    ifc.bus_addr_ok = 1'b1;
    settle();
    chk("st_addr", ifc.bus_addr, 32'h1000_0002);
    chk("st_wr", ifc.bus_wr, 1'b1);
    chk("st_size", ifc.bus_size, 2'd0);
    chk("st_wstrb", ifc.bus_wstrb, 4'b0100);
    chk("st_wdata", ifc.bus_wdata, 32'h00AB_0000);
    chk("st_addr_ok", ifc.data_addr_ok, 1'b1);
    chk("st_iside_aok", ifc.inst_addr_ok, 1'b0);
    advance();
    ifc.data_req = 1'b0;
    ifc.bus_addr_ok = 1'b0;
    ifc.bus_data_ok = 1'b1;
    settle();
    chk("st_data_ok", ifc.data_data_ok, 1'b1);
    chk("st_iside_dok", ifc.inst_data_ok, 1'b0);
    advance();
    clear_bus();
    step();
    ifc.inst_req = 1'b1;
    ifc.inst_addr = 32'h1C00_0100;
    ifc.data_req = 1'b1;
    ifc.data_wr = 1'b0;
    ifc.data_size = 2'd2;
    ifc.data_addr = 32'h0000_0040;
    ifc.bus_addr_ok = 1'b1;
    ifc.bus_data_ok = 1'b1;
    obs_grants.delete();
    for (int i = 0; i < 12; i++) begin
      settle();
      if (i > 0) chk("b2b_no_idle", ifc.bus_req, (i % 2) == 1);
      advance();
    end
    ifc.inst_req = 1'b0;
    ifc.data_req = 1'b0;
    step();
    clear_bus();
    step();
    chk("grant_count", obs_grants.size(), 6);
    for (int i = 0; i < 6 && i < obs_grants.size(); i++) chk($sformatf("grant_%0d", i), obs_grants[i], exp_order[i]);
    ifc.inst_req = 1'b1;
    ifc.inst_addr = 32'h1C00_0200;
    step();
    for (int i = 0; i < 4; i++) begin
      if (i == 1) ifc.data_req = 1'b1;
      settle();
      chk("lock_addr", ifc.bus_addr, 32'h1C00_0200);
      chk("lock_daok", ifc.data_addr_ok, 1'b0);
      advance();
    end
    ifc.bus_addr_ok = 1'b1;
    settle();
    chk("lock_iaok", ifc.inst_addr_ok, 1'b1);
    chk("lock_daok2", ifc.data_addr_ok, 1'b0);
    advance();
    ifc.inst_req = 1'b0;
    ifc.bus_addr_ok = 1'b0;
    ifc.bus_data_ok = 1'b1;
    settle();
    chk("lock_idok", ifc.inst_data_ok, 1'b1);
    advance();
    ifc.bus_data_ok = 1'b0;
    ifc.bus_addr_ok = 1'b1;
    settle();
    chk("lock_dgrant", ifc.data_addr_ok, 1'b1);
    chk("lock_daddr", ifc.bus_addr, 32'h0000_0040);
    advance();
    ifc.data_req = 1'b0;
    ifc.bus_addr_ok = 1'b0;
    ifc.bus_data_ok = 1'b1;
    step();
    ifc.bus_addr_ok = 1'b1;
    settle();
    chk("spur_idok", ifc.inst_data_ok, 1'b0);
    chk("spur_ddok", ifc.data_data_ok, 1'b0);
    chk("spur_iaok", ifc.inst_addr_ok, 1'b0);
    advance();
    clear_bus();
    ifc.inst_req = 1'b1;
    step();
    ifc.bus_addr_ok = 1'b1;
    step();
    ifc.inst_req = 1'b0;
    ifc.bus_addr_ok = 1'b0;
    reset = 1'b1;
    step();
    reset = 1'b0;
    ifc.bus_data_ok = 1'b1;
    settle();
    chk("rst_mid_req", ifc.bus_req, 1'b0);
    chk("rst_mid_idok", ifc.inst_data_ok, 1'b0);
    advance();
    clear_bus();
    step();
    for (int n = 0; n < 600; n++) begin
      if (!ifc.inst_req && $urandom_range(1, 0) == 1) begin
        ifc.inst_req = 1'b1;
        ifc.inst_addr = $urandom;
      end
      if (!ifc.data_req && $urandom_range(1, 0) == 1) begin
        ifc.data_req = 1'b1;
        ifc.data_wr = 1'($urandom_range(1, 0));
        ifc.data_size = 2'($urandom_range(2, 0));
        ifc.data_wstrb = 4'($urandom);
        ifc.data_addr = $urandom;
        ifc.data_wdata = $urandom;
      end
      ifc.bus_addr_ok = 1'($urandom_range(1, 0));
      ifc.bus_data_ok = 1'($urandom_range(1, 0));
      ifc.bus_rdata = $urandom;
      reset = $urandom_range(63, 0) == 0;
      i_acc = ph == 1 && who == 0 && ifc.bus_addr_ok;
      d_acc = ph == 1 && who == 1 && ifc.bus_addr_ok;
      step();
      if (i_acc) ifc.inst_req = 1'b0;
      if (d_acc) ifc.data_req = 1'b0;
    end
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
